// File: rtl/screen_region_walker_pkg.sv
// Shared screen definitions for the region walker and its initiators.
// FSM state encoding plus default framebuffer geometry.
package screen_region_walker_pkg;

  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;
  localparam int WIDTH_DEF    = 16;
  localparam int COLOUR_W_DEF = 3;
  localparam int ADDR_W_DEF   = 17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_WRITE,
    S_NEXT,
    S_DONE
  } walk_state_t;

endpackage

// File: rtl/screen_region_walker_addr_calc.sv
// Maps a pixel coordinate to a linear framebuffer address.
// Off-screen pixels report in_bounds=0 and address 0.
module screen_addr_calc
  import screen_region_walker_pkg::*;
#(
  parameter int CW       = WIDTH_DEF + 1,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic [CW-1:0]     x,
  input  logic [CW-1:0]     y,
  output logic [ADDR_W-1:0] addr,
  output logic              in_bounds
);

  localparam logic [CW-1:0] XLIM = CW'(SCREEN_W);
  localparam logic [CW-1:0] YLIM = CW'(SCREEN_H);
  localparam logic [ADDR_W-1:0] ROW = ADDR_W'(SCREEN_W);

  assign in_bounds = (x < XLIM) && (y < YLIM);
  assign addr = in_bounds ? ADDR_W'(y) * ROW + ADDR_W'(x)
                          : '0;

endmodule

// File: rtl/screen_region_walker.sv
// Walks a rectangular screen region pixel by pixel, doing a
// read-modify-write of each on-screen framebuffer location.
module screen_region_walker
  import screen_region_walker_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int COLOUR_W = COLOUR_W_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                screen_start,
  input  logic [COLOUR_W-1:0] new_screen_colour,
  input  logic [WIDTH-1:0]    screen_x_min,
  input  logic [WIDTH-1:0]    screen_y_min,
  input  logic [WIDTH-1:0]    screen_x_range,
  input  logic [WIDTH-1:0]    screen_y_range,
  output logic [WIDTH-1:0]    screen_x,
  output logic [WIDTH-1:0]    screen_y,
  output logic [COLOUR_W-1:0] old_screen_colour,
  output logic                screen_done,
  output logic                screen_busy,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd_en,
  input  logic [COLOUR_W-1:0] mem_rd_data,
  output logic                mem_wr_en,
  output logic [COLOUR_W-1:0] mem_wr_data
);

  // One spare bit so origin+range never wraps around.
  localparam int CW = WIDTH + 1;

  walk_state_t state, state_n;
  logic [CW-1:0] cx, cy, cx_n, cy_n;
  logic [CW-1:0] x0, x_end, y_end;
  logic          empty, is_empty;
  logic          enter;
  logic [ADDR_W-1:0] addr_n;
  logic          in_bounds;

  assign is_empty = (screen_x_range == '0) ||
                    (screen_y_range == '0);

  screen_addr_calc #(
    .CW       (CW),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .ADDR_W   (ADDR_W)
  ) u_addr (
    .x         (cx_n),
    .y         (cy_n),
    .addr      (addr_n),
    .in_bounds (in_bounds)
  );

  always_comb begin
    state_n = state;
    cx_n    = cx;
    cy_n    = cy;
    enter   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (screen_start) begin
          cx_n = CW'(screen_x_min);
          cy_n = CW'(screen_y_min);
          if (is_empty) state_n = S_NEXT;
          else          enter   = 1'b1;
        end
      end
      S_READ:    state_n = S_CAPTURE;
      S_CAPTURE: state_n = S_WRITE;
      // An in-bounds pixel advances straight out of WRITE.
      S_WRITE, S_NEXT: begin
        if (empty) begin
          state_n = S_DONE;
        end else if (cx + 1'b1 != x_end) begin
          cx_n  = cx + 1'b1;
          enter = 1'b1;
        end else if (cy + 1'b1 != y_end) begin
          cx_n  = x0;
          cy_n  = cy + 1'b1;
          enter = 1'b1;
        end else begin
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (enter) state_n = in_bounds ? S_READ : S_NEXT;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      cx                <= '0;
      cy                <= '0;
      x0                <= '0;
      x_end             <= '0;
      y_end             <= '0;
      empty             <= 1'b0;
      old_screen_colour <= '0;
      mem_addr          <= '0;
    end else begin
      state    <= state_n;
      cx       <= cx_n;
      cy       <= cy_n;
      mem_addr <= addr_n;
      if (state == S_IDLE && screen_start) begin
        x0    <= CW'(screen_x_min);
        x_end <= CW'(screen_x_min) + CW'(screen_x_range);
        y_end <= CW'(screen_y_min) + CW'(screen_y_range);
        empty <= is_empty;
      end
      if (state == S_CAPTURE)
        old_screen_colour <= mem_rd_data;
      else if (state_n == S_NEXT)
        old_screen_colour <= '0;
    end
  end

  assign screen_x    = cx[WIDTH-1:0];
  assign screen_y    = cy[WIDTH-1:0];
  assign mem_rd_en   = (state == S_READ);
  assign mem_wr_en   = (state == S_WRITE);
  assign mem_wr_data = mem_wr_en ? new_screen_colour : '0;
  assign screen_done = (state == S_DONE);
  assign screen_busy = (state != S_IDLE) &&
                       (state != S_DONE);

endmodule

// File: tb/tb_screen_region_walker.sv
// Self-checking bench for screen_region_walker with a framebuffer
// model and a loop-based reference of the region walk.
module tb_screen_region_walker;

  localparam int SW   = 320;
  localparam int SH   = 240;
  localparam int NPIX = SW * SH;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        screen_start = 1'b0;
  logic [2:0]  new_screen_colour;
  logic [15:0] x_min = '0, y_min = '0;
  logic [15:0] x_range = '0, y_range = '0;
  logic [15:0] screen_x, screen_y;
  logic [2:0]  old_screen_colour;
  logic        screen_done, screen_busy;
  logic [16:0] mem_addr;
  logic        mem_rd_en, mem_wr_en;
  logic [2:0]  mem_rd_data;
  logic [2:0]  mem_wr_data;

  logic [2:0]  fixed_colour = 3'd0;
  bit          use_fn = 1'b0;
  logic [2:0]  mem [NPIX];
  logic [2:0]  ref_mem [NPIX];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_addr_q[$], wr_data_q[$], wr_old_q[$], rd_q[$];
  int both_cnt = 0, done_cnt = 0, done_cyc = -1, start_cyc = 0;
  int exp_addr[$], exp_data[$], exp_old[$];
  int exp_lat = 0;

  screen_region_walker dut (
    .clock             (clock),
    .reset             (reset),
    .screen_start      (screen_start),
    .new_screen_colour (new_screen_colour),
    .screen_x_min      (x_min),
    .screen_y_min      (y_min),
    .screen_x_range    (x_range),
    .screen_y_range    (y_range),
    .screen_x          (screen_x),
    .screen_y          (screen_y),
    .old_screen_colour (old_screen_colour),
    .screen_done       (screen_done),
    .screen_busy       (screen_busy),
    .mem_addr          (mem_addr),
    .mem_rd_en         (mem_rd_en),
    .mem_rd_data       (mem_rd_data),
    .mem_wr_en         (mem_wr_en),
    .mem_wr_data       (mem_wr_data)
  );

  // Initiator: either a fixed fill colour or a function of old/x/y.
  assign new_screen_colour = use_fn ?
    (old_screen_colour ^ screen_x[2:0] ^ screen_y[2:0]) : fixed_colour;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mem_rd_en && int'(mem_addr) < NPIX)
      mem_rd_data <= mem[mem_addr];
    if (mem_wr_en && int'(mem_addr) < NPIX)
      mem[mem_addr] = mem_wr_data;
  end

  always @(negedge clock) begin
    if (mem_rd_en) rd_q.push_back(int'(mem_addr));
    if (mem_wr_en) begin
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(int'(mem_wr_data));
      wr_old_q.push_back(int'(old_screen_colour));
    end
    if (mem_rd_en && mem_wr_en) both_cnt++;
    if (screen_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic int q_diff(input int got[$], input int want[$]);
    int n;
    n = (got.size() > want.size()) ? got.size() - want.size()
                                   : want.size() - got.size();
    for (int i = 0; i < got.size() && i < want.size(); i++)
      if (got[i] != want[i]) n++;
    return n;
  endfunction

  // Reference walk: row-major over the region, on-screen pixels cost
  // read+capture+write, off-screen ones a single cycle.
  task automatic build_expect(input int x0, input int y0,
                              input int xr, input int yr);
    int a, d;
    exp_addr.delete();
    exp_data.delete();
    exp_old.delete();
    exp_lat = 0;
    for (int y = y0; y < y0 + yr; y++)
      for (int x = x0; x < x0 + xr; x++)
        if (x < SW && y < SH) begin
          a = y * SW + x;
          d = use_fn ? ((int'(ref_mem[a]) ^ x ^ y) & 7)
                     : int'(fixed_colour);
          exp_addr.push_back(a);
          exp_old.push_back(int'(ref_mem[a]));
          exp_data.push_back(d);
          ref_mem[a] = 3'(d);
          exp_lat += 3;
        end else begin
          exp_lat += 1;
        end
    exp_lat = (xr == 0 || yr == 0) ? 2 : exp_lat + 1;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_old_q.delete();
    rd_q.delete();
    both_cnt = 0;
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic start_walk(input int x, input int y,
                            input int xr, input int yr);
    @(posedge clock); #1;
    x_min = 16'(x);
    y_min = 16'(y);
    x_range = 16'(xr);
    y_range = 16'(yr);
    screen_start = 1'b1;
    start_cyc = cyc;
    @(posedge clock); #1;
    screen_start = 1'b0;
  endtask

  task automatic finish_walk(input int budget, output bit ok);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    ok = (done_cnt != 0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({screen_x, screen_y, old_screen_colour, mem_addr,
         mem_wr_data} !== '0) begin
      failures++;
      $display("FAIL reset_values got x=%0d y=%0d old=%0d addr=%0d wd=%0d want all 0",
               screen_x, screen_y, old_screen_colour, mem_addr, mem_wr_data);
    end
    checks++;
    if ({mem_rd_en, mem_wr_en, screen_done, screen_busy} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags got rd=%b wr=%b done=%b busy=%b want 0",
               mem_rd_en, mem_wr_en, screen_done, screen_busy);
    end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (screen_busy !== 1'b0 || screen_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got busy=%b done=%b want 0 0",
               screen_busy, screen_done);
    end
  endtask

  task automatic test_basic();
    int want[4] = '{6410, 6411, 6730, 6731};
    bit ok;
    foreach (want[i]) begin
      mem[want[i]] = 3'b010;
      ref_mem[want[i]] = 3'b010;
    end
    use_fn = 1'b0;
    fixed_colour = 3'b101;
    build_expect(10, 20, 2, 2);
    clear_logs();
    start_walk(10, 20, 2, 2);
    @(negedge clock);
    checks++;
    if (screen_busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy got %b want 1", screen_busy);
    end
    finish_walk(100, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL basic_timeout got no done want done");
    end
    checks++;
    if (wr_addr_q.size() != 4 || q_diff(wr_addr_q, exp_addr) != 0 ||
        wr_addr_q[0] != want[0] || wr_addr_q[3] != want[3]) begin
      failures++;
      $display("FAIL basic_wr_addr got n=%0d want 4 writes 6410..6731",
               wr_addr_q.size());
    end
    checks++;
    if (q_diff(rd_q, exp_addr) != 0) begin
      failures++;
      $display("FAIL basic_rd_addr got n=%0d want 4 reads",
               rd_q.size());
    end
    checks++;
    if (q_diff(wr_old_q, exp_old) != 0 ||
        q_diff(wr_data_q, exp_data) != 0) begin
      failures++;
      $display("FAIL basic_colours got old/data mismatch want old=2 data=5");
    end
    checks++;
    if (done_cnt != 1 || done_cyc - start_cyc != 13) begin
      failures++;
      $display("FAIL basic_done got cnt=%0d lat=%0d want cnt=1 lat=13",
               done_cnt, done_cyc - start_cyc);
    end
  endtask

  task automatic test_empty();
    bit ok;
    build_expect(50, 60, 0, 5);
    clear_logs();
    start_walk(50, 60, 0, 5);
    finish_walk(20, ok);
    checks++;
    if (!ok || rd_q.size() != 0 || wr_addr_q.size() != 0) begin
      failures++;
      $display("FAIL empty_access got ok=%b rd=%0d wr=%0d want 1 0 0",
               ok, rd_q.size(), wr_addr_q.size());
    end
    checks++;
    if (done_cnt != 1 || done_cyc - start_cyc != 2) begin
      failures++;
      $display("FAIL empty_done got cnt=%0d lat=%0d want cnt=1 lat=2",
               done_cnt, done_cyc - start_cyc);
    end
  endtask

  task automatic test_edge();
    bit ok;
    use_fn = 1'b0;
    fixed_colour = 3'b011;
    build_expect(318, 239, 4, 2);
    clear_logs();
    start_walk(318, 239, 4, 2);
    finish_walk(60, ok);
    checks++;
    if (!ok || wr_addr_q.size() != 2 || q_diff(wr_addr_q, exp_addr) != 0 ||
        wr_addr_q[0] != 76798 || wr_addr_q[1] != 76799) begin
      failures++;
      $display("FAIL edge_writes got ok=%b n=%0d want 76798 76799",
               ok, wr_addr_q.size());
    end
    checks++;
    if (done_cnt != 1 || done_cyc - start_cyc != exp_lat) begin
      failures++;
      $display("FAIL edge_done got cnt=%0d lat=%0d want cnt=1 lat=%0d",
               done_cnt, done_cyc - start_cyc, exp_lat);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    build_expect(65534, 5, 4, 2);
    clear_logs();
    start_walk(65534, 5, 4, 2);
    finish_walk(40, ok);
    checks++;
    if (!ok || wr_addr_q.size() != 0 || rd_q.size() != 0) begin
      failures++;
      $display("FAIL overflow_access got ok=%b wr=%0d rd=%0d want 1 0 0",
               ok, wr_addr_q.size(), rd_q.size());
    end
    checks++;
    if (done_cnt != 1 || done_cyc - start_cyc != exp_lat) begin
      failures++;
      $display("FAIL overflow_done got cnt=%0d lat=%0d want cnt=1 lat=%0d",
               done_cnt, done_cyc - start_cyc, exp_lat);
    end
  endtask

  task automatic test_ignore_start();
    bit ok;
    use_fn = 1'b0;
    fixed_colour = 3'b110;
    build_expect(100, 50, 3, 1);
    clear_logs();
    start_walk(100, 50, 3, 1);
    repeat (4) @(posedge clock);
    #1;
    x_min = 16'd0;
    y_min = 16'd0;
    x_range = 16'd2;
    y_range = 16'd2;
    screen_start = 1'b1;
    @(posedge clock); #1;
    screen_start = 1'b0;
    finish_walk(60, ok);
    checks++;
    if (!ok || q_diff(wr_addr_q, exp_addr) != 0) begin
      failures++;
      $display("FAIL ignore_writes got ok=%b n=%0d want 3 writes",
               ok, wr_addr_q.size());
    end
    checks++;
    if (done_cnt != 1 || done_cyc - start_cyc != exp_lat) begin
      failures++;
      $display("FAIL ignore_done got cnt=%0d lat=%0d want cnt=1 lat=%0d",
               done_cnt, done_cyc - start_cyc, exp_lat);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit hit = 1'b0;
    logic [2:0] keep;
    use_fn = 1'b0;
    fixed_colour = 3'b011;
    keep = mem[6411];
    clear_logs();
    start_walk(10, 20, 2, 2);
    for (int n = 0; n < 20 && !hit; n++) begin
      if (mem_wr_en && screen_x == 16'd11) hit = 1'b1;
      else begin
        @(posedge clock); #1;
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL midreset_reach got no WRITE of pixel 2 want reached");
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({screen_x, screen_y, old_screen_colour, mem_addr, mem_wr_data,
         mem_rd_en, mem_wr_en, screen_done, screen_busy} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got x=%0d addr=%0d wr=%b busy=%b want 0",
               screen_x, mem_addr, mem_wr_en, screen_busy);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    ref_mem[6410] = 3'b011;
    checks++;
    if (wr_addr_q.size() != 1 || done_cnt != 0 || mem[6411] !== keep) begin
      failures++;
      $display("FAIL midreset_abandon got wr=%0d done=%0d want 1 0",
               wr_addr_q.size(), done_cnt);
    end
    build_expect(7, 7, 1, 1);
    clear_logs();
    start_walk(7, 7, 1, 1);
    finish_walk(20, ok);
    checks++;
    if (!ok || wr_addr_q.size() != 1 || wr_addr_q[0] != 2247 ||
        done_cnt != 1 || done_cyc - start_cyc != 4) begin
      failures++;
      $display("FAIL midreset_restart got ok=%b wr=%0d done=%0d want 1 1 1",
               ok, wr_addr_q.size(), done_cnt);
    end
  endtask

  task automatic test_random();
    bit ok;
    int x, y, xr, yr;
    use_fn = 1'b1;
    for (int it = 0; it < 24; it++) begin
      x = ($urandom_range(0, 3) == 0) ? $urandom_range(314, 325)
                                      : $urandom_range(0, 310);
      y = ($urandom_range(0, 3) == 0) ? $urandom_range(236, 245)
                                      : $urandom_range(0, 230);
      xr = $urandom_range(0, 6);
      yr = $urandom_range(0, 5);
      build_expect(x, y, xr, yr);
      clear_logs();
      start_walk(x, y, xr, yr);
      finish_walk(200, ok);
      checks++;
      if (!ok || q_diff(wr_addr_q, exp_addr) != 0 ||
          q_diff(rd_q, exp_addr) != 0) begin
        failures++;
        $display("FAIL rand%0d_addr got ok=%b wr=%0d rd=%0d want %0d",
                 it, ok, wr_addr_q.size(), rd_q.size(), exp_addr.size());
      end
      checks++;
      if (q_diff(wr_old_q, exp_old) != 0 ||
          q_diff(wr_data_q, exp_data) != 0) begin
        failures++;
        $display("FAIL rand%0d_colour got %0d/%0d diffs want 0",
                 it, q_diff(wr_old_q, exp_old), q_diff(wr_data_q, exp_data));
      end
      checks++;
      if (done_cnt != 1 || done_cyc - start_cyc != exp_lat ||
          both_cnt != 0) begin
        failures++;
        $display("FAIL rand%0d_done got cnt=%0d lat=%0d both=%0d want 1 %0d 0",
                 it, done_cnt, done_cyc - start_cyc, both_cnt, exp_lat);
      end
    end
  endtask

  task automatic test_clear();
    bit ok;
    int bad = 0;
    use_fn = 1'b0;
    fixed_colour = 3'b111;
    build_expect(0, 0, 40, 30);
    clear_logs();
    start_walk(0, 0, 40, 30);
    finish_walk(4000, ok);
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 40; x++)
        if (mem[y * SW + x] !== 3'b111) bad++;
    checks++;
    if (!ok || wr_addr_q.size() != 1200 || bad != 0) begin
      failures++;
      $display("FAIL clear_fill got ok=%b writes=%0d bad=%0d want 1 1200 0",
               ok, wr_addr_q.size(), bad);
    end
    checks++;
    if (done_cnt != 1 || done_cyc - start_cyc != exp_lat) begin
      failures++;
      $display("FAIL clear_done got cnt=%0d lat=%0d want cnt=1 lat=%0d",
               done_cnt, done_cyc - start_cyc, exp_lat);
    end
  endtask

  task automatic test_memory_image();
    int bad = 0;
    for (int i = 0; i < NPIX; i++)
      if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL memory_image got %0d differing words want 0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) begin
      mem[i] = 3'($urandom_range(0, 7));
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_basic();
    test_empty();
    test_edge();
    test_overflow();
    test_ignore_start();
    test_reset_mid();
    test_random();
    test_clear();
    test_memory_image();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
